// File: rtl/dadda_product_accumulator.sv
// Sums a stream of unsigned products into a guarded accumulator and holds each finished sum for a handshake.
// Optional build macro DADDA_ACC_SATURATE_EN: clamp the accumulator on carry-out instead of wrapping.
module dadda_product_accumulator #(
    parameter int N         = 16,
    parameter int G         = 8,
    parameter int MAX_TERMS = 256,
    parameter int CNT_W     = 9
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2*N-1:0]       in_prod,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*N+G-1:0]     acc_out,
    output logic [CNT_W-1:0]     term_cnt,
    output logic                 ovf,
    output logic                 forced
);
    localparam int ACC_W = 2*N+G;
    localparam int SUM_W = ACC_W+1;

    typedef enum logic {ACCUM, HOLD} state_t;

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ovf_q, ovf_d;
    logic               forced_q, forced_d;

    logic [SUM_W-1:0]   sum;
    logic [CNT_W-1:0]   cnt_inc;
    logic               hit_max;

    // Extra top bit of sum is the carry out of the accumulator.
    assign sum     = {1'b0, acc_q} + SUM_W'(in_prod);
    assign cnt_inc = cnt_q + 1'b1;
    assign hit_max = (cnt_inc == CNT_W'(MAX_TERMS));

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        ovf_d     = ovf_q;
        forced_d  = forced_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            ACCUM: begin
                in_ready = 1'b1;
                if (in_valid) begin
`ifdef DADDA_ACC_SATURATE_EN
                    acc_d = (sum[ACC_W] || ovf_q) ? '1 : sum[ACC_W-1:0];
`else
                    acc_d = sum[ACC_W-1:0];
`endif
                    cnt_d = cnt_inc;
                    ovf_d = ovf_q | sum[ACC_W];
                    if (in_last || hit_max) begin
                        state_d  = HOLD;
                        forced_d = hit_max && !in_last;
                    end
                end
            end
            HOLD: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d  = ACCUM;
                    acc_d    = '0;
                    cnt_d    = '0;
                    ovf_d    = 1'b0;
                    forced_d = 1'b0;
                end
            end
            default: state_d = ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ACCUM;
            acc_q    <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
            forced_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
            forced_q <= forced_d;
        end
    end

    assign acc_out  = acc_q;
    assign term_cnt = cnt_q;
    assign ovf      = ovf_q;
    assign forced   = forced_q;
endmodule

// File: tb/tb_dadda_product_accumulator.sv
// Directed bench: three accumulator configurations share one input stream; a selector picks which one is checked.
module tb_dadda_product_accumulator;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] in_prod = '0;
    logic        in_last = 1'b0;
    logic        out_ready = 1'b0;

    logic        rdy0, ov0, ovf0, frc0;
    logic [39:0] acc0;
    logic [8:0]  cnt0;
    logic        rdy1, ov1, ovf1, frc1;
    logic [33:0] acc1;
    logic [3:0]  cnt1;
    logic        rdy2, ov2, ovf2, frc2;
    logic [39:0] acc2;
    logic [2:0]  cnt2;

    int          sel = 0;
    logic        m_rdy, m_ov, m_ovf, m_frc;
    logic [63:0] m_acc;
    logic [63:0] m_cnt;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    dadda_product_accumulator u0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy0), .in_prod(in_prod),
        .in_last(in_last), .out_valid(ov0), .out_ready(out_ready), .acc_out(acc0),
        .term_cnt(cnt0), .ovf(ovf0), .forced(frc0));

    dadda_product_accumulator #(.N(16), .G(2), .MAX_TERMS(8), .CNT_W(4)) u1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy1), .in_prod(in_prod),
        .in_last(in_last), .out_valid(ov1), .out_ready(out_ready), .acc_out(acc1),
        .term_cnt(cnt1), .ovf(ovf1), .forced(frc1));

    dadda_product_accumulator #(.N(16), .G(8), .MAX_TERMS(4), .CNT_W(3)) u2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy2), .in_prod(in_prod),
        .in_last(in_last), .out_valid(ov2), .out_ready(out_ready), .acc_out(acc2),
        .term_cnt(cnt2), .ovf(ovf2), .forced(frc2));

    always_comb begin
        case (sel)
            1: begin
                m_rdy = rdy1; m_ov = ov1; m_ovf = ovf1; m_frc = frc1;
                m_acc = 64'(acc1); m_cnt = 64'(cnt1);
            end
            2: begin
                m_rdy = rdy2; m_ov = ov2; m_ovf = ovf2; m_frc = frc2;
                m_acc = 64'(acc2); m_cnt = 64'(cnt2);
            end
            default: begin
                m_rdy = rdy0; m_ov = ov0; m_ovf = ovf0; m_frc = frc0;
                m_acc = 64'(acc0); m_cnt = 64'(cnt0);
            end
        endcase
    end

    typedef struct {
        int          sel;
        int          nb;
        logic [31:0] p0, p1, p2;   // beats 2.. repeat p2
        logic        last;
        logic [63:0] acc;
        int          cnt;
        logic        ovf;
        logic        forced;
    } vec_t;

    vec_t tbl [8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        in_last = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic run_row(input vec_t v, input int idx);
        do_reset();
        sel = v.sel;
        out_ready = 1'b1;
        for (int i = 0; i < v.nb; i++) begin
            in_valid = 1'b1;
            in_prod  = (i == 0) ? v.p0 : (i == 1) ? v.p1 : v.p2;
            in_last  = v.last && (i == v.nb - 1);
            tick();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        chk($sformatf("row%0d_out_valid", idx), 64'(m_ov), 64'd1);
        chk($sformatf("row%0d_acc", idx), m_acc, v.acc);
        chk($sformatf("row%0d_cnt", idx), m_cnt, 64'(v.cnt));
        chk($sformatf("row%0d_ovf", idx), 64'(m_ovf), 64'(v.ovf));
        chk($sformatf("row%0d_forced", idx), 64'(m_frc), 64'(v.forced));
        tick();
        chk($sformatf("row%0d_in_ready_after", idx), 64'(m_rdy), 64'd1);
        chk($sformatf("row%0d_out_valid_after", idx), 64'(m_ov), 64'd0);
        out_ready = 1'b0;
    endtask

    initial begin
        logic [63:0] five_exp;
        logic [31:0] b2b [4];
        int cyc;
        int w;
`ifdef DADDA_ACC_SATURATE_EN
        five_exp = 64'h3_FFFF_FFFF;
`else
        five_exp = 64'h0_FFF6_0005;
`endif
        tbl[0] = '{0, 3, 32'd6, 32'd15, 32'd0, 1'b1, 64'd21, 3, 1'b0, 1'b0};
        tbl[1] = '{1, 5, 32'hFFFE0001, 32'hFFFE0001, 32'hFFFE0001, 1'b1, five_exp, 5, 1'b1, 1'b0};
        tbl[2] = '{1, 4, 32'hFFFE0001, 32'hFFFE0001, 32'hFFFE0001, 1'b1, 64'h3_FFF8_0004, 4, 1'b0, 1'b0};
        tbl[3] = '{2, 4, 32'd1, 32'd1, 32'd1, 1'b0, 64'd4, 4, 1'b0, 1'b1};
        tbl[4] = '{1, 8, 32'd1, 32'd1, 32'd1, 1'b0, 64'd8, 8, 1'b0, 1'b1};
        tbl[5] = '{1, 8, 32'd2, 32'd2, 32'd2, 1'b1, 64'd16, 8, 1'b0, 1'b0};
        tbl[6] = '{0, 1, 32'hFFFE0001, 32'd0, 32'd0, 1'b1, 64'hFFFE0001, 1, 1'b0, 1'b0};
        tbl[7] = '{0, 2, 32'd0, 32'd0, 32'd0, 1'b1, 64'd0, 2, 1'b0, 1'b0};

        // Reset state
        do_reset();
        sel = 0;
        chk("rst_in_ready", 64'(m_rdy), 64'd1);
        chk("rst_out_valid", 64'(m_ov), 64'd0);
        chk("rst_acc", m_acc, 64'd0);
        chk("rst_cnt", m_cnt, 64'd0);
        chk("rst_ovf", 64'(m_ovf), 64'd0);
        chk("rst_forced", 64'(m_frc), 64'd0);

        for (int r = 0; r < 8; r++) run_row(tbl[r], r);

        // Output stall: upstream beat 9 waits through HOLD, then opens the next sum
        do_reset();
        sel = 0;
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_prod = 32'd6;  in_last = 1'b0; tick();
        in_prod = 32'd15; tick();
        in_prod = 32'd0;  in_last = 1'b1; tick();
        in_prod = 32'd9;  in_last = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("hold%0d_out_valid", i), 64'(m_ov), 64'd1);
            chk($sformatf("hold%0d_acc", i), m_acc, 64'd21);
            chk($sformatf("hold%0d_in_ready", i), 64'(m_rdy), 64'd0);
            tick();
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("hold_release_in_ready", 64'(m_rdy), 64'd1);
        chk("hold_release_cnt", m_cnt, 64'd0);
        in_last = 1'b1;
        tick();
        in_valid = 1'b0;
        in_last = 1'b0;
        chk("hold_next_out_valid", 64'(m_ov), 64'd1);
        chk("hold_next_acc", m_acc, 64'd9);
        chk("hold_next_cnt", m_cnt, 64'd1);

        // Forced close at MAX_TERMS=4; the fifth beat stalls then opens a new sum
        do_reset();
        sel = 2;
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_prod = 32'd1;
        in_last = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("max_forced", 64'(m_frc), 64'd1);
        for (int i = 0; i < 3; i++) tick();
        chk("max_stall_in_ready", 64'(m_rdy), 64'd0);
        chk("max_stall_cnt", m_cnt, 64'd4);
        chk("max_stall_acc", m_acc, 64'd4);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        chk("max_fifth_cnt", m_cnt, 64'd1);
        chk("max_fifth_acc", m_acc, 64'd1);
        chk("max_fifth_out_valid", 64'(m_ov), 64'd0);
        chk("max_fifth_forced", 64'(m_frc), 64'd0);

        // Reset mid-sum discards the partial sum
        do_reset();
        sel = 0;
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_prod = 32'd7; tick();
        in_prod = 32'd8; tick();
        in_valid = 1'b0;
        chk("midrst_partial_acc", m_acc, 64'd15);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_in_ready", 64'(m_rdy), 64'd1);
        chk("midrst_out_valid", 64'(m_ov), 64'd0);
        chk("midrst_cnt", m_cnt, 64'd0);
        in_valid = 1'b1;
        in_prod = 32'd5;
        in_last = 1'b1;
        tick();
        in_valid = 1'b0;
        in_last = 1'b0;
        chk("midrst_single_acc", m_acc, 64'd5);
        chk("midrst_single_cnt", m_cnt, 64'd1);
        chk("midrst_single_out_valid", 64'(m_ov), 64'd1);

        // Back-to-back single-beat sums: one result every 2 cycles
        do_reset();
        sel = 0;
        out_ready = 1'b1;
        b2b[0] = 32'd3; b2b[1] = 32'd100; b2b[2] = 32'hFFFE0001; b2b[3] = 32'd0;
        cyc = 0;
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1;
            in_prod = b2b[k];
            in_last = 1'b1;
            w = 0;
            while (!m_rdy && w < 10) begin
                tick();
                w++;
                cyc++;
            end
            chk($sformatf("b2b%0d_wait_bound", k), 64'(w < 10), 64'd1);
            tick();
            cyc++;
            chk($sformatf("b2b%0d_out_valid", k), 64'(m_ov), 64'd1);
            chk($sformatf("b2b%0d_acc", k), m_acc, 64'(b2b[k]));
            chk($sformatf("b2b%0d_cnt", k), m_cnt, 64'd1);
        end
        in_valid = 1'b0;
        in_last = 1'b0;
        chk("b2b_total_cycles", 64'(cyc), 64'd7);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1);
    end
endmodule
